// File: rtl/ncl_seq_pkg.sv
// ncl_seq_pkg: shared states, fault codes and dual-rail predicates for the wavefront sequencer
package ncl_seq_pkg;
  localparam int MAX_W = 64;
  typedef enum logic [2:0] {S_IDLE, S_ARB, S_DATA, S_NULL, S_ERROR} state_t;
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_RAIL = 2'd2;
  // Callers zero-extend to MAX_W; bits at and above w are masked off
  function automatic logic dr_complete(input logic [MAX_W-1:0] r1, input logic [MAX_W-1:0] r0, input int w);
    logic [MAX_W-1:0] m;
    m = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
    return &((r1 ^ r0) | ~m);
  endfunction
  function automatic logic dr_null(input logic [MAX_W-1:0] r1, input logic [MAX_W-1:0] r0);
    return ~|(r1 | r0);
  endfunction
  function automatic logic dr_illegal(input logic [MAX_W-1:0] r1, input logic [MAX_W-1:0] r0);
    return |(r1 & r0);
  endfunction
endpackage

// File: rtl/ncl_wavefront_sequencer_sync.sv
// ncl_rail_sync: 2-flop rail synchronizer with a 2-sample stability filter on complete/null
module ncl_rail_sync
  import ncl_seq_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] r1_a,
  input  logic [W-1:0] r0_a,
  output logic [W-1:0] r1,
  output logic         complete,
  output logic         is_null,
  output logic         illegal
);
  logic [W-1:0] r1_m, r0_m, r0;
  logic cmp_q, nul_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      r1_m <= '0;
      r0_m <= '0;
      r1 <= '0;
      r0 <= '0;
      cmp_q <= 1'b0;
      nul_q <= 1'b0;
    end else begin
      r1_m <= r1_a;
      r0_m <= r0_a;
      r1 <= r1_m;
      r0 <= r0_m;
      cmp_q <= dr_complete(MAX_W'(r1), MAX_W'(r0), W);
      nul_q <= dr_null(MAX_W'(r1), MAX_W'(r0));
    end
  end
  assign complete = cmp_q && dr_complete(MAX_W'(r1), MAX_W'(r0), W);
  assign is_null = nul_q && dr_null(MAX_W'(r1), MAX_W'(r0));
  assign illegal = dr_illegal(MAX_W'(r1), MAX_W'(r0));
endmodule

// File: rtl/ncl_wavefront_sequencer.sv
// ncl_wavefront_sequencer: round-robin sharing of one NCL dual-rail pipeline among synchronous requesters
module ncl_wavefront_sequencer
  import ncl_seq_pkg::*;
#(
  parameter int W = 8,
  parameter int N_REQ = 4,
  parameter int TIMEOUT = 255,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_valid,
  input  logic [N_REQ*W-1:0] req_data,
  output logic [N_REQ-1:0] req_ready,
  output logic             rsp_valid,
  output logic [IW-1:0]    rsp_id,
  output logic [W-1:0]     rsp_data,
  output logic [W-1:0]     ncl_d1,
  output logic [W-1:0]     ncl_d0,
  input  logic             ncl_ki,
  input  logic [W-1:0]     ncl_r1,
  input  logic [W-1:0]     ncl_r0,
  output logic             ncl_ko,
  output logic             err,
  output logic [1:0]       err_code
);
  state_t st, st_n;
  logic [IW-1:0] ptr, ptr_n, gid, gid_n, g, rsp_id_n;
  logic [W-1:0] op, op_n, res, res_n, rsp_data_n, d1_n, d0_n, r1_s;
  logic [15:0] cnt, cnt_n;
  logic [N_REQ-1:0] rdy_n;
  logic [1:0] code_n;
  logic ko_n, rv_n, err_n, found, ki_m, ki_s, complete, is_null, illegal;
  ncl_rail_sync #(.W(W)) u_sync (
    .clk(clk), .rst(rst), .r1_a(ncl_r1), .r0_a(ncl_r0),
    .r1(r1_s), .complete(complete), .is_null(is_null), .illegal(illegal)
  );
  always_comb begin
    found = 1'b0;
    g = '0;
    for (int i = 0; i < N_REQ; i++)
      if (!found && req_valid[(int'(ptr) + i) % N_REQ]) begin
        found = 1'b1;
        g = IW'((int'(ptr) + i) % N_REQ);
      end
  end
  always_comb begin
    st_n = st;
    ptr_n = ptr;
    op_n = op;
    gid_n = gid;
    res_n = res;
    ko_n = ncl_ko;
    rdy_n = '0;
    rv_n = 1'b0;
    err_n = err;
    code_n = err_code;
    cnt_n = (st == S_DATA || st == S_NULL) ? cnt + 16'd1 : '0;
    case (st)
      S_IDLE: st_n = (|req_valid && ki_s) ? S_ARB : S_IDLE;
      S_ARB: begin
        st_n = found ? S_DATA : S_IDLE;
        ptr_n = found ? IW'((int'(g) + 1) % N_REQ) : ptr;
        rdy_n[g] = found;
        op_n = found ? req_data[int'(g)*W +: W] : op;
        gid_n = found ? g : gid;
      end
      S_DATA:
        if (!ki_s && complete) begin
          res_n = r1_s;
          ko_n = 1'b0;
          st_n = S_NULL;
          cnt_n = '0;
        end else if (cnt == 16'(TIMEOUT)) begin
          st_n = S_ERROR;
          code_n = ERR_TIMEOUT;
        end
      S_NULL:
        if (ki_s && is_null) begin
          ko_n = 1'b1;
          rv_n = 1'b1;
          st_n = S_IDLE;
        end else if (cnt == 16'(TIMEOUT)) begin
          st_n = S_ERROR;
          code_n = ERR_TIMEOUT;
        end
      default: ;
    endcase
    // A rail fault outranks everything, including a same-cycle grant or response
    if (st != S_ERROR && illegal) begin
      st_n = S_ERROR;
      code_n = ERR_RAIL;
      rdy_n = '0;
      rv_n = 1'b0;
    end
    err_n = (st_n == S_ERROR) ? 1'b1 : err_n;
    ko_n = (st_n == S_ERROR) ? 1'b1 : ko_n;
    rsp_id_n = rv_n ? gid : rsp_id;
    rsp_data_n = rv_n ? res : rsp_data;
    d1_n = (st_n == S_DATA) ? op_n : '0;
    d0_n = (st_n == S_DATA) ? ~op_n : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= S_IDLE;
      ptr <= '0;
      op <= '0;
      gid <= '0;
      res <= '0;
      cnt <= '0;
      ki_m <= 1'b0;
      ki_s <= 1'b0;
      ncl_d1 <= '0;
      ncl_d0 <= '0;
      ncl_ko <= 1'b1;
      req_ready <= '0;
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_data <= '0;
      err <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      st <= st_n;
      ptr <= ptr_n;
      op <= op_n;
      gid <= gid_n;
      res <= res_n;
      cnt <= cnt_n;
      ki_m <= ncl_ki;
      ki_s <= ki_m;
      ncl_d1 <= d1_n;
      ncl_d0 <= d0_n;
      ncl_ko <= ko_n;
      req_ready <= rdy_n;
      rsp_valid <= rv_n;
      rsp_id <= rsp_id_n;
      rsp_data <= rsp_data_n;
      err <= err_n;
      err_code <= code_n;
    end
  end
endmodule

// File: tb/tb_ncl_wavefront_sequencer.sv
// tb_ncl_wavefront_sequencer: random requesters, identity NCL pipeline model and response scoreboard
module tb_ncl_wavefront_sequencer;
  localparam int W = 8;
  localparam int N = 4;
  localparam int TO = 40;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_p = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0] req_ready;
  logic rsp_valid;
  logic [1:0] rsp_id;
  logic [W-1:0] rsp_data, ncl_d1, ncl_d0;
  logic [W-1:0] ncl_r1 = '0;
  logic [W-1:0] ncl_r0 = '0;
  logic ncl_ki = 1'b1;
  logic ncl_ko, err;
  logic [1:0] err_code;
  ncl_wavefront_sequencer #(.W(W), .N_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .ncl_d1(ncl_d1), .ncl_d0(ncl_d0),
    .ncl_ki(ncl_ki), .ncl_r1(ncl_r1), .ncl_r0(ncl_r0), .ncl_ko(ncl_ko), .err(err), .err_code(err_code)
  );
  always #5 clk = ~clk;
  always @(posedge clk) rst_p <= rst;
  int checks = 0;
  int errors = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // Pipeline model: identity transfer, each output bit delayed 3 cycles plus optional skew
  bit mrst = 1'b1, skew_en = 1'b0, hang = 1'b0, ill = 1'b0;
  int ph = 0, cyc = 0, kd = 0;
  int dly[W];
  logic [W-1:0] c1, c0;
  task automatic pick();
    kd = 3;
    for (int i = 0; i < W; i++) begin
      dly[i] = 3 + (skew_en ? int'($urandom_range(0, 5)) : 0);
      if (skew_en && dly[i] + 1 > kd) kd = dly[i] + 1;
    end
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    if (mrst) begin
      ph = 0;
      ncl_ki = 1'b1;
      ncl_r1 = '0;
      ncl_r0 = '0;
    end else
      case (ph)
        0: if (&(ncl_d1 ^ ncl_d0) && ncl_ko) begin
          c1 = ncl_d1;
          c0 = ncl_d0;
          pick();
          cyc = 0;
          ph = 1;
        end
        1: begin
          cyc++;
          for (int i = 0; i < W; i++) if (cyc == dly[i]) begin ncl_r1[i] = c1[i]; ncl_r0[i] = c0[i]; end
          if (cyc == kd && !hang) ncl_ki = 1'b0;
          if (cyc >= kd) ph = 2;
        end
        2: if (~|(ncl_d1 | ncl_d0) && !ncl_ko) begin
          pick();
          cyc = 0;
          ph = 3;
        end
        default: begin
          cyc++;
          for (int i = 0; i < W; i++) if (cyc == dly[i]) begin ncl_r1[i] = 1'b0; ncl_r0[i] = 1'b0; end
          if (cyc == kd) ncl_ki = 1'b1;
          if (cyc >= kd) ph = 0;
        end
      endcase
    if (ill) begin
      ncl_r1[0] = 1'b1;
      ncl_r0[0] = 1'b1;
    end
  end
  // Requester agent with round-robin reference; pushes expected responses
  typedef struct {int id; logic [W-1:0] data;} exp_t;
  exp_t q[$];
  exp_t cur;
  int gorder[$];
  int ref_ptr = 0, hold_left = 0, load_seq = 0, load_seen = 0, e = 0, last_g = -1, rsp_cnt = 0;
  logic [N-1:0] pend_valid;
  logic [N*W-1:0] pend_data;
  int pend_hold;
  always @(negedge clk) begin
    if (rst_p) begin
      req_valid = '0;
      ref_ptr = 0;
      hold_left = 0;
    end else begin
      if (req_ready != '0) begin
        e = -1;
        for (int k = 0; k < N; k++) if (e < 0 && req_valid[(ref_ptr + k) % N]) e = (ref_ptr + k) % N;
        if (e < 0) chk("grant_unexpected", req_ready, 0);
        else begin
          chk("grant", req_ready, 64'(1) << e);
          cur.id = e;
          cur.data = req_data[e*W +: W];
          q.push_back(cur);
          gorder.push_back(e);
          last_g = e;
          ref_ptr = (e + 1) % N;
          if (hold_left > 0) begin
            hold_left--;
            if (hold_left == 0) req_valid = '0;
            else req_data[e*W +: W] = W'($urandom);
          end else req_valid[e] = 1'b0;
        end
      end
      if (load_seq != load_seen) begin
        load_seen = load_seq;
        req_valid = pend_valid;
        req_data = pend_data;
        hold_left = pend_hold;
        gorder.delete();
      end
    end
  end
  always @(negedge clk) begin
    if (rst_p) q.delete();
    else if (rsp_valid) begin
      rsp_cnt++;
      if (q.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
      else begin
        cur = q.pop_front();
        chk("rsp_id", rsp_id, cur.id);
        chk("rsp_data", rsp_data, cur.data);
        chk("rsp_rails_null", ncl_d1 | ncl_d0, 0);
        chk("rsp_ko", ncl_ko, 1);
      end
    end
  end
  task automatic load(input logic [N-1:0] m, input logic [N*W-1:0] d, input int h);
    pend_valid = m;
    pend_data = d;
    pend_hold = h;
    load_seq++;
    repeat (2) @(negedge clk);
  endtask
  function automatic logic [N*W-1:0] rnd_data();
    logic [N*W-1:0] d;
    for (int i = 0; i < N; i++) d[i*W +: W] = W'($urandom);
    return d;
  endfunction
  task automatic wait_quiet(input string nm, input int budget);
    int n = 0;
    while ((req_valid != '0 || q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_drain"}, 64'(req_valid != '0 || q.size() != 0), 0);
  endtask
  task automatic wait_data(input string nm);
    int n = 0;
    while ((ncl_d1 | ncl_d0) == '0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_data_phase"}, 64'((ncl_d1 | ncl_d0) != '0), 1);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    mrst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mrst = 1'b0;
    repeat (3) @(negedge clk);
  endtask
  initial begin
    logic [N*W-1:0] d;
    int n, base;
    repeat (3) @(negedge clk);
    chk("rst_d1", ncl_d1, 0);
    chk("rst_d0", ncl_d0, 0);
    chk("rst_ko", ncl_ko, 1);
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_err", err, 0);
    chk("rst_err_code", err_code, 0);
    rst = 1'b0;
    mrst = 1'b0;
    repeat (3) @(negedge clk);
    d = '0;
    d[2*W +: W] = 8'hA5;
    load(4'b0100, d, 0);
    wait_quiet("single", 100);
    chk("single_grant", last_g, 2);
    chk("single_id", rsp_id, 2);
    chk("single_data", rsp_data, 8'hA5);
    chk("single_rails", ncl_d1 | ncl_d0, 0);
    do_reset();
    load(4'hF, rnd_data(), 8);
    wait_quiet("fair", 300);
    chk("fair_count", gorder.size(), 8);
    for (int k = 0; k < 8; k++) chk("fair_order", k < gorder.size() ? gorder[k] : -1, k % 4);
    skew_en = 1'b1;
    repeat (12) begin
      load(N'($urandom_range(1, 15)), rnd_data(), 0);
      wait_quiet("skew", 400);
    end
    skew_en = 1'b0;
    do_reset();
    hang = 1'b1;
    base = rsp_cnt;
    load(4'b0001, rnd_data(), 0);
    wait_data("timeout");
    n = 0;
    while (!err && n < TO + 20) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycles", n, TO + 1);
    chk("timeout_code", err_code, 1);
    chk("timeout_rails", ncl_d1 | ncl_d0, 0);
    chk("timeout_ko", ncl_ko, 1);
    repeat (5) @(negedge clk);
    chk("timeout_no_rsp", rsp_cnt, base);
    chk("timeout_sticky", err, 1);
    hang = 1'b0;
    do_reset();
    base = rsp_cnt;
    load(4'b0010, rnd_data(), 0);
    wait_data("illegal");
    ill = 1'b1;
    n = 0;
    while (err_code != 2'd2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("illegal_code", err_code, 2);
    chk("illegal_within4", 64'(n <= 4), 1);
    chk("illegal_err", err, 1);
    chk("illegal_no_rsp", rsp_cnt, base);
    ill = 1'b0;
    do_reset();
    load(4'b0010, rnd_data(), 0);
    wait_data("midrst");
    @(negedge clk);
    rst = 1'b1;
    mrst = 1'b1;
    @(negedge clk);
    chk("midrst_d1", ncl_d1, 0);
    chk("midrst_d0", ncl_d0, 0);
    chk("midrst_ko", ncl_ko, 1);
    chk("midrst_err", err, 0);
    rst = 1'b0;
    mrst = 1'b0;
    repeat (3) @(negedge clk);
    load(4'hF, rnd_data(), 0);
    wait_quiet("midrst", 300);
    chk("midrst_ptr", gorder.size() > 0 ? gorder[0] : -1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ncl_wavefront_sequencer.md
# ncl_wavefront_sequencer

Clocked controller that shares one NCL dual-rail pipeline between `N_REQ` synchronous requesters. It drives alternating DATA and NULL wavefronts into the pipeline. It observes the pipeline's input-completion and output rails through synchronizers and returns each result to the granted requester. It sits at the sync/async boundary, in front of the threshold-gate pipelines built from `th22n`/`th22d`-style cells.

## Interface
- `W`, default 8: data width, in dual-rail bits.
- `N_REQ`, default 4: number of requesters, range 2..8.
- `TIMEOUT`, default 255: cycle budget for each wavefront phase. Range 1..65535.

- `clk`  in  1  system clock.
- `rst`  in  1  reset: synchronous, active-high.
- `req_valid`  in  N_REQ  per-requester request.
- `req_data`  in  N_REQ*W  per-requester operand; requester i occupies bits [i*W +: W].
- `req_ready`  out  N_REQ  one-hot, 1-cycle grant/accept pulse.
- `rsp_valid`  out  1  1-cycle result pulse.
- `rsp_id`  out  $clog2(N_REQ)  index of the requester that owns the result.
- `rsp_data`  out  W  decoded result.
- `ncl_d1`, `ncl_d0`  out  W each  dual-rail operand to the pipeline; both rails 0 means NULL.
- `ncl_ki`  in  1  pipeline input completion, asynchronous. 1 = request DATA, 0 = request NULL.
- `ncl_r1`, `ncl_r0`  in  W each  dual-rail pipeline output, asynchronous.
- `ncl_ko`  out  1  acknowledge to the pipeline output. 1 = request DATA, 0 = request NULL.
- `err`  out  1  sticky fault flag.
- `err_code`  out  2  fault code: 0 none, 1 timeout, 2 illegal rail (both rails high).

## Operation
- Reset values: `ncl_d1`=`ncl_d0`=0 (NULL), `ncl_ko`=1, `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `err`=0, `err_code`=0, state IDLE, round-robin pointer 0.
- `ncl_ki` and every bit of `ncl_r1`/`ncl_r0` pass through 2-flop synchronizers.
  - Rails may be synchronized bitwise because NCL rails are monotonic within a phase.
  - Output is "complete" when every bit has exactly one rail high. It is "null" when all rails are 0.
  - Either condition counts only after it holds on 2 consecutive synchronized samples (stable).
- A bit with both rails high on the synchronized rails is illegal. Illegal rails in any state except ERROR force ERROR with code 2.
- States:
  - IDLE: rails NULL, `ncl_ko`=1. Go to ARB when any `req_valid` is set and synced `ncl_ki`=1.
  - ARB (1 cycle): grant the first requester at or after the pointer.
    - Pulse `req_ready[g]`, latch `req_data[g]` and `g`.
    - Pointer becomes g+1 modulo N_REQ.
    - Go to DATA.
  - DATA: drive `ncl_d1`=operand, `ncl_d0`=~operand.
    - Wait for synced `ncl_ki`=0 AND stable complete output.
    - Then capture `ncl_r1` into the result register, set `ncl_ko`=0, and go to NULL.
  - NULL: drive rails to 0.
    - Wait for synced `ncl_ki`=1 AND stable null output.
    - Then set `ncl_ko`=1, pulse `rsp_valid` carrying the captured id and data, and go to IDLE.
  - ERROR: rails NULL, `ncl_ko`=1, `err`=1. The block leaves ERROR only on `rst`.
- The phase counter resets on entry to DATA and on entry to NULL. If it reaches `TIMEOUT` before the exit condition, go to ERROR with code 1.
- `rsp_id`/`rsp_data` hold their values until the next `rsp_valid`.
- A requester dropping `req_valid` outside ARB has no effect. An accepted request always completes or errors.

## Timing
- Rail outputs, `ncl_ko`, `req_ready` and `rsp_valid` are all registered. No combinational path runs from async inputs to outputs.
- Minimum request-to-`rsp_valid` latency: 1 (ARB) + 4 (DATA: 2 sync + 2 stable) + 4 (NULL) = 9 cycles after IDLE samples `req_valid`.
- Back-to-back requests: IDLE → ARB takes 1 cycle, so the minimum issue interval is 10 cycles.
- Simultaneous requests: the round-robin order decides; no requester waits more than N_REQ−1 grants.
- `rst` mid-operation: the next edge returns rails to NULL and `ncl_ko` to 1.
  - Any pending response is dropped.
  - The bench must reset the pipeline concurrently.
- The DATA exit condition is a logical AND evaluated in the same cycle; order of arrival of ki and completion is irrelevant.
- The timeout check and the completion condition can both become true in the same cycle. Completion wins.

## Structure
- `ncl_seq_pkg`:
  - state enum (IDLE, ARB, DATA, NULL, ERROR);
  - err_code constants;
  - functions `dr_complete`, `dr_null`, `dr_illegal` over W-bit rail pairs.
- Sub-module `ncl_rail_sync`: 2-flop synchronizer plus 2-sample stability filter for a W-bit rail pair. It outputs `complete`, `is_null`, `illegal` and the synced `r1`. The main FSM instantiates it once; `ncl_ki` uses a 1-bit synchronizer inside the main FSM.

## Test plan
- Single request: requester 2 sends 0xA5 into an identity pipeline model with 3-cycle async delays. Expect `req_ready[2]` pulsed, `rsp_id`=2, `rsp_data`=0xA5, rails NULL after the response.
- Fairness: all 4 `req_valid` held high for 8 transactions. Expect grant order 0,1,2,3,0,1,2,3.
- Skewed completion: the model raises output bits with 0–5 cycle random skew and drops `ncl_ki` after completion. Expect no early capture and a correct result every time.
- Timeout: the model never drops `ncl_ki` in DATA. Expect `err`=1, `err_code`=1 at TIMEOUT+1 cycles into DATA, rails NULL, no `rsp_valid`.
- Illegal rail: force `ncl_r1[0]`=`ncl_r0[0]`=1 during DATA. Expect `err_code`=2 within 4 cycles.
- Reset mid-DATA: assert `rst` for 1 cycle. Expect rails 0, `ncl_ko`=1 and `err`=0 on the next edge, with the pointer restarting at requester 0.
